stopwatch_ctrl: RTL
===================

# stopwatch_ctrl

Control sequencer for the stopwatch datapath. It converts the debounced start/stop and lap/reset buttons into run, freeze and clear controls through a four-state FSM. It also generates the 1 Hz count-enable strobe from the 100 MHz system clock, so the counter datapath runs in the system clock domain and needs no derived clock. It sits between the button debouncers and the hour/min/sec counter block inside the stopwatch top level.

## Interface
- TICK_DIV, 100_000_000: system-clock cycles per tick strobe (≥2).
- LONG_PRESS, 200_000_000: cycles lap_reset must be held to force a clear (≥2).
- clk_100MHz  in  1  system clock; all logic on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- btn_start_stop  in  1  debounced, synchronous level; rising edge toggles run/pause.
- btn_lap_reset  in  1  debounced, synchronous level; rising edge gives lap or reset; a long hold forces a clear.
- tick  out  1  one-cycle count-enable strobe to the counters.
- run  out  1  high in RUN and LAP.
- freeze  out  1  high in LAP; the display holds its captured value.
- clear  out  1  one-cycle pulse that zeroes the counters.
- state  out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 LAP.

## Operation
- Edge detect: each button has a registered copy btn_q. rise = btn & ~btn_q. btn_q resets to 1, so a button held through reset release gives no edge.
- FSM:
  - IDLE: ss rise → RUN.
  - RUN: ss rise → PAUSE. lap rise → LAP.
  - LAP: ss rise → PAUSE (freeze drops). lap rise → RUN (freeze drops).
  - PAUSE: ss rise → RUN. lap rise → IDLE with clear pulse.
- Simultaneous rises on the same cycle: start_stop wins and the lap edge is discarded. The lap hold counter still starts.
- Prescaler, width clog2(TICK_DIV):
  - Increments only in RUN or LAP.
  - tick=1 on the cycle the prescaler equals TICK_DIV-1; the prescaler wraps to 0 on the same edge.
  - Holds its value in PAUSE, so partial seconds are preserved.
  - Forced to 0 on IDLE entry and on any clear.
- Long press:
  - hold_cnt, width clog2(LONG_PRESS+1), counts cycles while btn_lap_reset=1 and resets to 0 when the button is low.
  - When hold_cnt reaches LONG_PRESS-1 while the button is still high, from any state: clear pulses for one cycle, the FSM goes to IDLE, and the prescaler goes to 0.
  - hold_cnt then saturates. Only one long-press clear fires per hold; re-arming requires release.
- The short-press action happens at the rising edge. A long press can follow it; for example RUN → LAP → IDLE.
- clear never asserts outside a PAUSE lap press or a long press.
- run and freeze are decoded from the registered state. tick and clear are registered pulses.

## Timing
- Reset (async assert, sync release): state=IDLE; tick=0, run=0, freeze=0, clear=0; prescaler=0, hold_cnt=0; btn_q=1.
- Button to control latency is 1 cycle. A level rising before edge N changes state, run and freeze after edge N.
- After IDLE→RUN on edge N, the first tick is high during the cycle after edge N+TICK_DIV-1. Ticks then repeat every TICK_DIV cycles.
- A pause/resume sequence does not alter tick phase within the second; the sum of RUN and LAP cycles between ticks is always TICK_DIV.
- A clear pulse from PAUSE asserts the cycle after the lap edge. A clear from long press asserts the cycle after hold_cnt reaches LONG_PRESS-1, which is LONG_PRESS cycles after the button went high.
- tick and clear are never high together. When clear fires, tick is suppressed on that cycle.
- Reset mid-operation: outputs return to reset values immediately, with no clock needed.

## Test plan
Bench parameters: TICK_DIV=4, LONG_PRESS=10.
- Reset release with btn_start_stop held high → state stays 00, no tick. Release then press → state 01 the cycle after the press edge, ticks at 4-cycle intervals.
- RUN 6 cycles, pause 5 cycles, resume → next tick after exactly 2 more RUN cycles; prescaler frozen during PAUSE; tick=0 throughout PAUSE.
- RUN, lap press → state 11, freeze=1, ticks continue every 4 cycles. Second lap press → state 01, freeze=0.
- PAUSE, lap press for 1 cycle → one-cycle clear, state 00, prescaler 0. Held 30 cycles from RUN → LAP on the edge, then exactly one clear 10 cycles after press, state 00.
- Both buttons rise on the same cycle in RUN → state 10, no LAP entry. Lap held 10 cycles → clear and state 00.
- resetn pulsed low mid-LAP → run=0, freeze=0, state=00 asynchronously. After release, first ss press restarts with the full 4-cycle delay to the first tick.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button edge/long-press FSM plus 1 Hz tick prescaler.
// In: clk_100MHz, resetn, btn_start_stop, btn_lap_reset. Out: tick, run, freeze, clear, state[1:0].
module stopwatch_ctrl #(
  parameter int TICK_DIV   = 100_000_000,
  parameter int LONG_PRESS = 200_000_000
) (
  input  logic       clk_100MHz,
  input  logic       resetn,
  input  logic       btn_start_stop,
  input  logic       btn_lap_reset,
  output logic       tick,
  output logic       run,
  output logic       freeze,
  output logic       clear,
  output logic [1:0] state
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int HW = $clog2(LONG_PRESS + 1);

  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] P_PRE  = PW'(TICK_DIV - 2);
  localparam logic [HW-1:0] H_FIRE = HW'(LONG_PRESS - 1);
  localparam logic [HW-1:0] H_SAT  = HW'(LONG_PRESS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_LAP   = 2'b11
  } state_t;

  state_t          r_state;
  state_t          w_nxt;
  logic            r_ss_q;
  logic            r_lap_q;
  logic [PW-1:0]   r_presc;
  logic [HW-1:0]   r_hold;
  logic            r_tick;
  logic            r_clear;

  logic            w_ss_rise;
  logic            w_lap_rise;
  logic            w_long;
  logic            w_lap_clr;
  logic            w_clr;
  logic            w_running;

  assign w_ss_rise  = btn_start_stop & ~r_ss_q;
  assign w_lap_rise = btn_lap_reset & ~r_lap_q;
  assign w_long     = btn_lap_reset & (r_hold == H_FIRE);
  assign w_running  = (r_state == S_RUN) | (r_state == S_LAP);
  assign w_clr      = w_long | w_lap_clr;

  // Long press beats everything; start/stop beats a same-cycle lap edge.
  always_comb begin
    w_nxt     = r_state;
    w_lap_clr = 1'b0;
    if (w_long) begin
      w_nxt = S_IDLE;
    end else if (w_ss_rise) begin
      case (r_state)
        S_IDLE:  w_nxt = S_RUN;
        S_RUN:   w_nxt = S_PAUSE;
        S_LAP:   w_nxt = S_PAUSE;
        S_PAUSE: w_nxt = S_RUN;
        default: w_nxt = S_IDLE;
      endcase
    end else if (w_lap_rise) begin
      case (r_state)
        S_RUN:   w_nxt = S_LAP;
        S_LAP:   w_nxt = S_RUN;
        S_PAUSE: begin
          w_nxt     = S_IDLE;
          w_lap_clr = 1'b1;
        end
        default: w_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk_100MHz or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_ss_q  <= 1'b1;
      r_lap_q <= 1'b1;
      r_presc <= '0;
      r_hold  <= '0;
      r_tick  <= 1'b0;
      r_clear <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_ss_q  <= btn_start_stop;
      r_lap_q <= btn_lap_reset;
      r_clear <= w_clr;
      // Tick is raised as the prescaler moves onto its last count,
      // so it is high while the prescaler holds TICK_DIV-1.
      r_tick  <= w_running & (r_presc == P_PRE) & ~w_clr;

      if (w_clr || w_nxt == S_IDLE) begin
        r_presc <= '0;
      end else if (w_running) begin
        if (r_presc == P_LAST) r_presc <= '0;
        else                   r_presc <= r_presc + 1'b1;
      end

      // Saturating at LONG_PRESS keeps the fire compare from re-matching.
      if (!btn_lap_reset)     r_hold <= '0;
      else if (r_hold != H_SAT) r_hold <= r_hold + 1'b1;
    end
  end

  assign tick   = r_tick;
  assign clear  = r_clear;
  assign state  = r_state;
  assign run    = w_running;
  assign freeze = (r_state == S_LAP);

endmodule
